// File: rtl/div_pkg.sv
// ============================================================================
// div_pkg : shared types and default sizes for the divergence controller
// Revision: 1.0
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DEF_N_CORES     = 4;
  localparam int DEF_STACK_DEPTH = 3;
  localparam int DEF_PC_W        = 8;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_IF    = 2'd1,
    OP_ELSE  = 2'd2,
    OP_ENDIF = 2'd3
  } op_type_e;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CHK_IF   = 2'd1,
    S_CHK_ELSE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/div_ctrl_if.sv
// ============================================================================
// div_ctrl_if : control-op, mask-stack and PC-redirect signals of div_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

interface div_ctrl_if #(
  parameter int N_CORES     = div_pkg::DEF_N_CORES,
  parameter int STACK_DEPTH = div_pkg::DEF_STACK_DEPTH,
  parameter int PC_W        = div_pkg::DEF_PC_W
) ();
  import div_pkg::*;

  logic                   op_valid;
  logic                   op_ready;
  op_type_e               op_type;
  logic [N_CORES-1:0]     pred;
  logic [PC_W-1:0]        else_pc;
  logic [PC_W-1:0]        endif_pc;
  logic [N_CORES-1:0]     tos;
  logic                   all_false;
  logic                   st_push;
  logic                   st_pop;
  logic                   st_comp;
  logic [N_CORES-1:0]     st_d_in;
  logic                   pc_load;
  logic [PC_W-1:0]        pc_target;
  logic [STACK_DEPTH-1:0] depth;
  logic                   err_ovf;
  logic                   err_udf;

  // Decoder / stack / PC side
  modport master (
    output op_valid, op_type, pred, else_pc, endif_pc, tos, all_false,
    input  op_ready, st_push, st_pop, st_comp, st_d_in,
    input  pc_load, pc_target, depth, err_ovf, err_udf
  );

  // Controller side
  modport slave (
    input  op_valid, op_type, pred, else_pc, endif_pc, tos, all_false,
    output op_ready, st_push, st_pop, st_comp, st_d_in,
    output pc_load, pc_target, depth, err_ovf, err_udf
  );

endinterface

`default_nettype wire

// File: rtl/div_depth_ctr.sv
// ============================================================================
// div_depth_ctr : saturating nesting-depth counter with sticky ovf/udf flags
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_depth_ctr #(
  parameter int STACK_DEPTH = 3
) (
  input  wire logic                   clk,
  input  wire logic                   reset,
  input  wire logic                   if_acc,
  input  wire logic                   else_acc,
  input  wire logic                   endif_acc,
  output logic [STACK_DEPTH-1:0]      depth,
  output logic                        at_max,
  output logic                        at_zero,
  output logic                        err_ovf,
  output logic                        err_udf
);

  localparam logic [STACK_DEPTH-1:0] C_MAX = '1;
  localparam logic [STACK_DEPTH-1:0] C_ONE = {{(STACK_DEPTH-1){1'b0}}, 1'b1};

  logic [STACK_DEPTH-1:0] r_depth;
  logic                   r_ovf;
  logic                   r_udf;

  assign at_max  = (r_depth == C_MAX);
  assign at_zero = (r_depth == '0);

  // Refused ops flag an error instead of moving the counter, so it never wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_depth <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (if_acc) begin
      if (at_max) r_ovf   <= 1'b1;
      else        r_depth <= r_depth + C_ONE;
    end else if (endif_acc) begin
      if (at_zero) r_udf   <= 1'b1;
      else         r_depth <= r_depth - C_ONE;
    end else if (else_acc && at_zero) begin
      r_udf <= 1'b1;
    end
  end

  assign depth   = r_depth;
  assign err_ovf = r_ovf;
  assign err_udf = r_udf;

endmodule

`default_nettype wire

// File: rtl/div_ctrl.sv
// ============================================================================
// div_ctrl : IF/ELSE/ENDIF divergence controller driving the predicate stack
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_ctrl
  import div_pkg::*;
#(
  parameter int N_CORES     = DEF_N_CORES,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int PC_W        = DEF_PC_W
) (
  input wire logic  clk,
  input wire logic  reset,
  div_ctrl_if.slave bus
);

  state_e                 r_state;
  state_e                 w_next;
  logic [PC_W-1:0]        r_saved_pc;
  logic [PC_W-1:0]        r_pc_target;
  logic                   w_acc;
  logic                   w_if_acc;
  logic                   w_else_acc;
  logic                   w_endif_acc;
  logic                   w_at_max;
  logic                   w_at_zero;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_comp;
  logic                   w_load;
  logic [N_CORES-1:0]     w_d_in;
  logic [STACK_DEPTH-1:0] w_depth;
  logic                   w_ovf;
  logic                   w_udf;
  logic                   w_ready;

  assign w_ready     = reset & (r_state == S_IDLE);
  assign w_acc       = bus.op_valid & w_ready;
  assign w_if_acc    = w_acc & (bus.op_type == OP_IF);
  assign w_else_acc  = w_acc & (bus.op_type == OP_ELSE);
  assign w_endif_acc = w_acc & (bus.op_type == OP_ENDIF);

  div_depth_ctr #(
    .STACK_DEPTH (STACK_DEPTH)
  ) u_depth (
    .clk       (clk),
    .reset     (reset),
    .if_acc    (w_if_acc),
    .else_acc  (w_else_acc),
    .endif_acc (w_endif_acc),
    .depth     (w_depth),
    .at_max    (w_at_max),
    .at_zero   (w_at_zero),
    .err_ovf   (w_ovf),
    .err_udf   (w_udf)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_push = 1'b0;
    w_pop  = 1'b0;
    w_comp = 1'b0;
    w_load = 1'b0;
    w_d_in = bus.pred & bus.tos;
    case (r_state)
      S_IDLE: begin
        if (w_if_acc && !w_at_max) begin
          w_push = 1'b1;
          w_next = S_CHK_IF;
        end else if (w_else_acc && !w_at_zero) begin
          w_comp = 1'b1;
          w_next = S_CHK_ELSE;
        end else if (w_endif_acc && !w_at_zero) begin
          w_pop = 1'b1;
        end
      end
      // The stack has absorbed the push/comp; all_false now reflects the new top
      S_CHK_IF, S_CHK_ELSE: begin
        w_load = bus.all_false;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_saved_pc  <= '0;
      r_pc_target <= '0;
    end else begin
      if (w_if_acc && !w_at_max)        r_saved_pc <= bus.else_pc;
      else if (w_else_acc && !w_at_zero) r_saved_pc <= bus.endif_pc;
      if (w_load) r_pc_target <= r_saved_pc;
    end
  end

  // Target is valid in the same cycle as the strobe, then held
  assign bus.pc_target = w_load ? r_saved_pc : r_pc_target;
  assign bus.pc_load   = w_load;
  assign bus.op_ready  = w_ready;
  assign bus.st_push   = w_push;
  assign bus.st_pop    = w_pop;
  assign bus.st_comp   = w_comp;
  assign bus.st_d_in   = w_d_in;
  assign bus.depth     = w_depth;
  assign bus.err_ovf   = w_ovf;
  assign bus.err_udf   = w_udf;

endmodule

`default_nettype wire

// File: tb/tb_div_ctrl.sv
// ============================================================================
// tb_div_ctrl : vector table plus redirect scoreboard for div_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_div_ctrl;
  import div_pkg::*;

  typedef struct {
    op_type_e   op;
    logic [3:0] pred;
    logic [3:0] tos;
    logic [7:0] else_pc;
    logic [7:0] endif_pc;
    logic       af;
    logic       e_push;
    logic       e_comp;
    logic       e_pop;
    logic [3:0] e_din;
    logic       e_load;
    logic [7:0] e_tgt;
    logic [2:0] e_depth;
    logic       e_ovf;
    logic       e_udf;
    logic       e_chk;
  } vec_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  logic [7:0] exp_q[$];
  logic [7:0] last_tgt;
  vec_t vecs[13];

  div_ctrl_if #(.N_CORES(4), .STACK_DEPTH(3), .PC_W(8)) bus ();

  div_ctrl #(.N_CORES(4), .STACK_DEPTH(3), .PC_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(op_type_e op, logic [3:0] pred, logic [3:0] tos,
                              logic [7:0] epc, logic [7:0] ipc, logic af,
                              logic push, logic comp, logic pop, logic [3:0] din,
                              logic load, logic [7:0] tgt, logic [2:0] dep,
                              logic ovf, logic udf, logic chkst);
    vec_t v;
    v.op = op; v.pred = pred; v.tos = tos; v.else_pc = epc; v.endif_pc = ipc;
    v.af = af; v.e_push = push; v.e_comp = comp; v.e_pop = pop; v.e_din = din;
    v.e_load = load; v.e_tgt = tgt; v.e_depth = dep; v.e_ovf = ovf;
    v.e_udf = udf; v.e_chk = chkst;
    return v;
  endfunction

  // Scoreboard: every redirect must match the oldest expected target
  always @(negedge clk) begin
    if (bus.pc_load) begin
      if (exp_q.size() == 0) begin
        chk("pc_load_unexpected", 32'(bus.pc_load), 32'd0);
      end else begin
        chk("pc_target_on_load", 32'(bus.pc_target), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic apply(input vec_t v, input int idx);
    int guard;
    step();
    guard = 0;
    while (!bus.op_ready && guard < 8) begin
      step();
      guard++;
    end
    if (!bus.op_ready) chk($sformatf("v%0d ready_timeout", idx), 32'(bus.op_ready), 32'd1);
    bus.op_valid  = 1'b1;
    bus.op_type   = v.op;
    bus.pred      = v.pred;
    bus.tos       = v.tos;
    bus.else_pc   = v.else_pc;
    bus.endif_pc  = v.endif_pc;
    bus.all_false = 1'b0;
    if (v.e_load) exp_q.push_back(v.e_tgt);
    @(negedge clk);
    chk($sformatf("v%0d st_push", idx), 32'(bus.st_push), 32'(v.e_push));
    chk($sformatf("v%0d st_comp", idx), 32'(bus.st_comp), 32'(v.e_comp));
    chk($sformatf("v%0d st_pop", idx),  32'(bus.st_pop),  32'(v.e_pop));
    if (v.e_push) chk($sformatf("v%0d st_d_in", idx), 32'(bus.st_d_in), 32'(v.e_din));
    step();
    bus.op_valid  = 1'b0;
    bus.all_false = v.af;
    @(negedge clk);
    chk($sformatf("v%0d depth", idx),    32'(bus.depth),    32'(v.e_depth));
    chk($sformatf("v%0d err_ovf", idx),  32'(bus.err_ovf),  32'(v.e_ovf));
    chk($sformatf("v%0d err_udf", idx),  32'(bus.err_udf),  32'(v.e_udf));
    chk($sformatf("v%0d op_ready", idx), 32'(bus.op_ready), 32'(!v.e_chk));
    if (!v.e_load) chk($sformatf("v%0d pc_target_hold", idx), 32'(bus.pc_target), 32'(last_tgt));
    #1;
    chk($sformatf("v%0d redirect_pending", idx), 32'(exp_q.size()), 32'd0);
    if (v.e_load) last_tgt = v.e_tgt;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    last_tgt = 8'h00;
    reset = 1'b0;
    bus.op_valid = 1'b0; bus.op_type = OP_NOP; bus.pred = '0; bus.tos = '0;
    bus.else_pc = '0; bus.endif_pc = '0; bus.all_false = 1'b0;

    //           op        pred     tos      else   endif  af    psh   cmp   pop   din      ld    tgt    dep   ovf   udf   chk
    vecs[0]  = mk(OP_IF,    4'b0101, 4'b1111, 8'h10, 8'h18, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 1'b1);
    vecs[1]  = mk(OP_IF,    4'b0000, 4'b0101, 8'h20, 8'h30, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h20, 3'd2, 1'b0, 1'b0, 1'b1);
    vecs[2]  = mk(OP_ELSE,  4'b0000, 4'b0000, 8'h00, 8'h30, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 8'h00, 3'd2, 1'b0, 1'b0, 1'b1);
    vecs[3]  = mk(OP_ENDIF, 4'b0000, 4'b0101, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0);
    vecs[4]  = mk(OP_ENDIF, 4'b0000, 4'b1111, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(OP_IF,    4'b0011, 4'b1111, 8'h40, 8'h48, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 1'b1);
    vecs[6]  = mk(OP_IF,    4'b1100, 4'b0011, 8'h50, 8'h58, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 8'h50, 3'd2, 1'b0, 1'b0, 1'b1);
    vecs[7]  = mk(OP_ELSE,  4'b0000, 4'b0000, 8'h00, 8'h58, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 8'h58, 3'd2, 1'b0, 1'b0, 1'b1);
    vecs[8]  = mk(OP_ENDIF, 4'b0000, 4'b0011, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0, 1'b0);
    vecs[9]  = mk(OP_ENDIF, 4'b0000, 4'b1111, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    vecs[10] = mk(OP_NOP,   4'b1111, 4'b1111, 8'h66, 8'h67, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    vecs[11] = mk(OP_ENDIF, 4'b0000, 4'b1111, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    vecs[12] = mk(OP_ELSE,  4'b0000, 4'b1111, 8'h00, 8'h70, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);

    #2;
    chk("op_ready_in_reset", 32'(bus.op_ready), 32'd0);
    step(); step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("rst op_ready",  32'(bus.op_ready), 32'd1);
    chk("rst depth",     32'(bus.depth),    32'd0);
    chk("rst strobes",   32'({bus.st_push, bus.st_pop, bus.st_comp, bus.pc_load}), 32'd0);
    chk("rst err",       32'({bus.err_ovf, bus.err_udf}), 32'd0);
    chk("rst pc_target", 32'(bus.pc_target), 32'd0);

    for (int i = 0; i < 13; i++) apply(vecs[i], i);

    // Fill the stack to its maximum depth, then one IF too many
    for (int i = 0; i < 7; i++)
      apply(mk(OP_IF, 4'b1111, 4'b1111, 8'h80, 8'h88, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111,
               1'b0, 8'h00, 3'(i + 1), 1'b0, 1'b1, 1'b1), 100 + i);
    apply(mk(OP_IF, 4'b1111, 4'b1111, 8'h90, 8'h98, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000,
             1'b0, 8'h00, 3'd7, 1'b1, 1'b1, 1'b0), 107);

    // Reset while the IF check is pending must drop the redirect
    step();
    bus.op_valid = 1'b1; bus.op_type = OP_IF; bus.pred = 4'b0000; bus.tos = 4'b1111;
    bus.else_pc = 8'h77;
    step();
    bus.op_valid = 1'b0; bus.all_false = 1'b1;
    reset = 1'b0;
    #1;
    chk("midrst pc_load",  32'(bus.pc_load),  32'd0);
    chk("midrst op_ready", 32'(bus.op_ready), 32'd0);
    @(negedge clk);
    chk("midrst depth", 32'(bus.depth), 32'd0);
    chk("midrst err",   32'({bus.err_ovf, bus.err_udf}), 32'd0);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("postrst op_ready",  32'(bus.op_ready),  32'd1);
    chk("postrst pc_load",   32'(bus.pc_load),   32'd0);
    chk("postrst pc_target", 32'(bus.pc_target), 32'd0);
    chk("final redirect_queue", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
